z_result_stage: RTL and testbench

Z_RESULT_STAGE -- requirements
Module: z_result_stage

---
 rtl/zstage_pkg.sv | 13 +
 rtl/zstage_fifo.sv | 57 +++++
 rtl/z_result_stage.sv | 110 +++++++++++
 tb/tb_z_result_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zstage_pkg.sv
// Shared definitions for the ALU result stage: opcodes, width classification, beat states.
package zstage_pkg;
   localparam int DEPTH_DEFAULT = 2;
   localparam logic [4:0] OP_MUL = 5'b00010;
   localparam logic [4:0] OP_DIV = 5'b00011;

   typedef enum logic {BEAT_LO, BEAT_HI} beat_t;

   // Wide results carry a meaningful HI half and are emitted as two beats.
   function automatic logic is_wide(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction
endpackage

// File: rtl/zstage_fifo.sv
// Result entry FIFO: DEPTH entries of {wide, hi, lo}, power-of-two depth with wrapping pointers.
module zstage_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_lo,
   input  logic [DATA_W-1:0]        push_hi,
   input  logic                     push_wide,
   input  logic                     pop,
   output logic [DATA_W-1:0]        rd_lo,
   output logic [DATA_W-1:0]        rd_hi,
   output logic                     rd_wide,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [2*DATA_W:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {push_wide, push_hi, push_lo};
   end

   assign {rd_wide, rd_hi, rd_lo} = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/z_result_stage.sv
// ALU result stage: buffers results and streams them as one (narrow) or two (wide LO/HI) beats.
// Optional ZSTAGE_FLAGS_EN adds registered zero_flag/neg_flag outputs.
module z_result_stage
   import zstage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_lo,
   input  logic [DATA_W-1:0] in_hi,
   input  logic [4:0]        in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [DATA_W-1:0] hi_q,
   output logic [DATA_W-1:0] lo_q,
   output logic              busy
`ifdef ZSTAGE_FLAGS_EN
   ,
   output logic              zero_flag,
   output logic              neg_flag
`endif
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [CW-1:0]     count;
   logic              push, pop, in_wide, rd_wide;
   logic [DATA_W-1:0] rd_lo, rd_hi, hi_d, lo_d;
   logic              init_q, init_d;
   beat_t             state_q, state_d;

   zstage_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .clr(clr),
      .push(push), .push_lo(in_lo), .push_hi(in_hi), .push_wide(in_wide),
      .pop(pop), .rd_lo(rd_lo), .rd_hi(rd_hi), .rd_wide(rd_wide),
      .count(count)
   );

   // init_q holds in_ready low while clr is asserted and until the first clean edge.
   assign in_wide   = is_wide(in_ctrl);
   assign in_ready  = init_q && (count < FULL_CNT);
   assign push      = in_valid && in_ready;
   assign out_valid = (count != '0);
   assign busy      = out_valid;
   assign out_data  = !out_valid ? '0 : ((state_q == BEAT_HI) ? rd_hi : rd_lo);
   assign out_last  = out_valid && ((state_q == BEAT_HI) || !rd_wide);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      init_d  = 1'b1;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (out_valid && out_ready) begin
         if (state_q == BEAT_LO && rd_wide) begin
            state_d = BEAT_HI;
         end else begin
            pop     = 1'b1;
            state_d = BEAT_LO;
         end
      end
      if (push && in_wide) begin
         hi_d = in_hi;
         lo_d = in_lo;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= BEAT_LO;
         init_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         init_q  <= init_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

`ifdef ZSTAGE_FLAGS_EN
   logic zero_d, neg_d;

   always_comb begin
      zero_d = zero_flag;
      neg_d  = neg_flag;
      if (push) begin
         zero_d = (in_lo == '0) && (!in_wide || (in_hi == '0));
         neg_d  = in_wide ? in_hi[DATA_W-1] : in_lo[DATA_W-1];
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         zero_flag <= 1'b0;
         neg_flag  <= 1'b0;
      end else begin
         zero_flag <= zero_d;
         neg_flag  <= neg_d;
      end
   end
`endif
endmodule

// File: tb/tb_z_result_stage.sv
// Bench for z_result_stage: queue-based reference model, per-cycle compare, directed + random stimulus.
module tb_z_result_stage;
   localparam int DW = 32;
   localparam int DP = 2;

   logic          clk = 1'b0;
   logic          clr = 1'b0;
   logic          in_valid, out_ready;
   logic          in_ready, out_valid, out_last, busy;
   logic [DW-1:0] in_lo, in_hi, out_data, hi_q, lo_q;
   logic [4:0]    in_ctrl;
`ifdef ZSTAGE_FLAGS_EN
   logic          zero_flag, neg_flag;
`endif

   z_result_stage #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_lo(in_lo), .in_hi(in_hi), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .hi_q(hi_q), .lo_q(lo_q), .busy(busy)
`ifdef ZSTAGE_FLAGS_EN
      , .zero_flag(zero_flag), .neg_flag(neg_flag)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: queue of pending results plus which half of the head is being shown.
   typedef struct {
      logic [DW-1:0] lo;
      logic [DW-1:0] hi;
      logic          wide;
   } ent_t;

   ent_t          q[$];
   bit            m_beat_hi = 0;
   bit            m_init = 0;
   logic [DW-1:0] m_hi = '0, m_lo = '0;
   bit            m_zf = 0, m_nf = 0;
   bit            m_acc, m_wide;

   function automatic bit m_in_ready();
      return m_init && (q.size() < DP);
   endfunction

   always @(posedge clk or posedge clr) begin
      if (clr) begin
         q.delete();
         m_beat_hi = 0; m_init = 0; m_hi = '0; m_lo = '0; m_zf = 0; m_nf = 0;
      end else begin
         m_acc  = in_valid && m_in_ready();
         m_wide = (in_ctrl == 5'd2) || (in_ctrl == 5'd3);
         if (q.size() > 0 && out_ready) begin
            if (!m_beat_hi && q[0].wide) m_beat_hi = 1;
            else begin
               void'(q.pop_front());
               m_beat_hi = 0;
            end
         end
         if (m_acc) begin
            q.push_back('{lo: in_lo, hi: in_hi, wide: m_wide});
            if (m_wide) begin m_hi = in_hi; m_lo = in_lo; end
            m_zf = (in_lo == 0) && (!m_wide || in_hi == 0);
            m_nf = m_wide ? in_hi[DW-1] : in_lo[DW-1];
         end
         m_init = 1;
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, m_in_ready());
      chk("out_valid", out_valid, q.size() > 0);
      chk("busy", busy, q.size() > 0);
      chk("hi_q", hi_q, m_hi);
      chk("lo_q", lo_q, m_lo);
      if (q.size() > 0) begin
         chk("out_data", out_data, m_beat_hi ? q[0].hi : q[0].lo);
         chk("out_last", out_last, m_beat_hi || !q[0].wide);
      end
`ifdef ZSTAGE_FLAGS_EN
      chk("zero_flag", zero_flag, m_zf);
      chk("neg_flag", neg_flag, m_nf);
`endif
   end

   task automatic drv(input logic v, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                      input logic [4:0] op, input logic rdy);
      in_valid = v; in_lo = lo; in_hi = hi; in_ctrl = op; out_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      drv(0, 0, 0, 0, 0);
      #1 clr = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_hi_q", hi_q, 0);
      chk("rst_lo_q", lo_q, 0);
      tick();
      clr = 1'b0;
      #1 chk("in_ready_before_edge", in_ready, 0);
      tick();
      chk("in_ready_after_edge", in_ready, 1);

      // narrow add
      drv(1, 32'h5, 0, 5'd0, 1);
      tick();
      drv(0, 0, 0, 0, 1);
      chk("add_valid", out_valid, 1);
      chk("add_data", out_data, 32'h5);
      chk("add_last", out_last, 1);
      chk("add_hi_q", hi_q, 0);
      chk("add_lo_q", lo_q, 0);
      tick();
      chk("add_done", out_valid, 0);

      // wide mul
      drv(1, 32'hDEADBEEF, 32'h1, 5'd2, 0);
      tick();
      drv(0, 0, 0, 0, 0);
      chk("mul_hi_q", hi_q, 32'h1);
      chk("mul_lo_q", lo_q, 32'hDEADBEEF);
      chk("mul_lo_beat", out_data, 32'hDEADBEEF);
      chk("mul_lo_last", out_last, 0);
      tick();
      chk("mul_lo_stall", out_data, 32'hDEADBEEF);
      out_ready = 1;
      tick();
      chk("mul_hi_beat", out_data, 32'h1);
      chk("mul_hi_last", out_last, 1);
      tick();
      chk("mul_done", out_valid, 0);

      // three narrows, third refused
      drv(1, 32'h11, 0, 5'd0, 0);
      tick();
      drv(1, 32'h22, 0, 5'd0, 0);
      tick();
      chk("full_in_ready", in_ready, 0);
      drv(1, 32'h33, 0, 5'd0, 0);
      tick();
      drv(0, 0, 0, 0, 1);
      chk("drain0", out_data, 32'h11);
      tick();
      chk("drain1", out_data, 32'h22);
      tick();
      chk("drain_empty", out_valid, 0);

      // wide stall in BEAT_HI
      drv(1, 32'hA5A50001, 32'h5A5A0002, 5'd3, 0);
      tick();
      drv(0, 0, 0, 0, 1);
      chk("div_lo", out_data, 32'hA5A50001);
      tick();
      out_ready = 0;
      for (int i = 0; i < 5; i++) begin
         chk("div_hi_hold", out_data, 32'h5A5A0002);
         chk("div_hi_last", out_last, 1);
         tick();
      end
      out_ready = 1;
      tick();
      chk("div_single_pop", out_valid, 0);

      // clr mid-transfer with another entry queued
      drv(1, 32'h1234, 32'h9999, 5'd2, 0);
      tick();
      drv(1, 32'h77, 0, 5'd0, 0);
      tick();
      drv(0, 0, 0, 0, 1);
      tick();
      chk("clr_pre_hi", out_data, 32'h9999);
      out_ready = 0;
      clr = 1'b1;
      #1;
      chk("clr_out_valid", out_valid, 0);
      chk("clr_busy", busy, 0);
      chk("clr_hi_q", hi_q, 0);
      chk("clr_in_ready", in_ready, 0);
      tick();
      clr = 1'b0;
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("clr_no_beat", out_valid, 0);
      end

`ifdef ZSTAGE_FLAGS_EN
      drv(1, 0, 0, 5'd3, 1);
      tick();
      chk("zero_flag_div", zero_flag, 1);
      drv(1, 32'h80000000, 0, 5'd1, 1);
      tick();
      chk("neg_flag_sub", neg_flag, 1);
      chk("zero_flag_sub", zero_flag, 0);
      drv(0, 0, 0, 0, 1);
      tick();
      tick();
`endif

      // randomized traffic with occasional clr pulses
      for (int n = 0; n < 3000; n++) begin
         tick();
         clr = ($urandom_range(0, 299) == 0);
         in_valid = ($urandom_range(0, 99) < 60);
         in_lo = $urandom();
         in_hi = $urandom();
         case ($urandom_range(0, 3))
            0: in_ctrl = 5'd2;
            1: in_ctrl = 5'd3;
            default: in_ctrl = 5'($urandom());
         endcase
         if ($urandom_range(0, 9) == 0) in_lo = 0;
         out_ready = ($urandom_range(0, 99) < 55);
      end
      tick();
      clr = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
